// File: rtl/spi_main_pair.sv
// SPI master and slave wired back-to-back on an internal mode-0 serial clock; one start = one full-duplex word swap.
// Optional build macro: SPI_MAIN_LSB_FIRST_EN selects LSB-first shifting on both sides (default MSB-first).
module spi_main_pair #(
    parameter int REG_WIDTH = 8,
    parameter int CLK_DIV   = 1
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    input  logic                 t_start,
    input  logic [REG_WIDTH-1:0] d_in_m,
    input  logic [REG_WIDTH-1:0] d_in_s,
    output logic [REG_WIDTH-1:0] d_out_m,
    output logic [REG_WIDTH-1:0] d_out_s,
    output logic                 mosi,
    output logic                 miso
);

    typedef enum logic [1:0] {IDLE, TRANSFER, DONE} state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(REG_WIDTH + 1);

    state_t               state;
    logic [DIV_W-1:0]     div_cnt;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 sck;
    logic                 t_start_q;
    logic [REG_WIDTH-1:0] tx_m, tx_s, rx_m, rx_s;
    logic [REG_WIDTH-1:0] tx_m_nxt, tx_s_nxt, rx_m_nxt, rx_s_nxt;
    logic                 tx_bit_m, tx_bit_s, first_bit_m, first_bit_s;

    // Shift direction is the only thing the optional build changes.
    always_comb begin
`ifdef SPI_MAIN_LSB_FIRST_EN
        tx_m_nxt    = tx_m >> 1;
        tx_s_nxt    = tx_s >> 1;
        tx_bit_m    = tx_m_nxt[0];
        tx_bit_s    = tx_s_nxt[0];
        first_bit_m = d_in_m[0];
        first_bit_s = d_in_s[0];
        rx_m_nxt    = REG_WIDTH'({miso, rx_m} >> 1);
        rx_s_nxt    = REG_WIDTH'({mosi, rx_s} >> 1);
`else
        tx_m_nxt    = tx_m << 1;
        tx_s_nxt    = tx_s << 1;
        tx_bit_m    = tx_m_nxt[REG_WIDTH-1];
        tx_bit_s    = tx_s_nxt[REG_WIDTH-1];
        first_bit_m = d_in_m[REG_WIDTH-1];
        first_bit_s = d_in_s[REG_WIDTH-1];
        rx_m_nxt    = REG_WIDTH'({rx_m, miso});
        rx_s_nxt    = REG_WIDTH'({rx_s, mosi});
`endif
    end

    always_ff @(posedge sys_clk or posedge rstn) begin
        if (rstn) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            sck       <= 1'b0;
            t_start_q <= 1'b0;
            tx_m      <= '0;
            tx_s      <= '0;
            rx_m      <= '0;
            rx_s      <= '0;
            d_out_m   <= '0;
            d_out_s   <= '0;
            mosi      <= 1'b0;
            miso      <= 1'b0;
        end else begin
            t_start_q <= t_start;
            case (state)
                IDLE: begin
                    if (t_start && !t_start_q) begin
                        tx_m    <= d_in_m;
                        tx_s    <= d_in_s;
                        mosi    <= first_bit_m;
                        miso    <= first_bit_s;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        sck     <= 1'b0;
                        state   <= TRANSFER;
                    end
                end
                TRANSFER: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        sck     <= ~sck;
                        if (!sck) begin
                            // Rising SCK: both ends sample the opposite line.
                            rx_m    <= rx_m_nxt;
                            rx_s    <= rx_s_nxt;
                            bit_cnt <= bit_cnt + 1'b1;
                        end else if (bit_cnt == CNT_W'(REG_WIDTH)) begin
                            // Falling edge after the last sample ends the word.
                            sck   <= 1'b0;
                            mosi  <= 1'b0;
                            miso  <= 1'b0;
                            state <= DONE;
                        end else begin
                            tx_m <= tx_m_nxt;
                            tx_s <= tx_s_nxt;
                            mosi <= tx_bit_m;
                            miso <= tx_bit_s;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    d_out_m <= rx_m;
                    d_out_s <= rx_s;
                    sck     <= 1'b0;
                    mosi    <= 1'b0;
                    miso    <= 1'b0;
                    bit_cnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_main_pair.sv
// Bench for spi_main_pair: word-level reference model checked every cycle plus directed literal checks.
module tb_spi_main_pair;

    localparam int W    = 8;
    localparam int D    = 1;
    localparam int LAST = 2 * W * D;

    logic         sys_clk;
    logic         rstn;
    logic         t_start;
    logic [W-1:0] d_in_m, d_in_s;
    logic [W-1:0] d_out_m, d_out_s;
    logic         mosi, miso;

    int total = 0;
    int bad   = 0;

    spi_main_pair #(.REG_WIDTH(W), .CLK_DIV(D)) dut (
        .sys_clk(sys_clk),
        .rstn   (rstn),
        .t_start(t_start),
        .d_in_m (d_in_m),
        .d_in_s (d_in_s),
        .d_out_m(d_out_m),
        .d_out_s(d_out_s),
        .mosi   (mosi),
        .miso   (miso)
    );

    // clock / reset
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Reference model: a word transfer is a window of LAST+1 cycles after the start edge;
    // bit j of the serial stream is on the line for 2*D cycles, then results appear.
    logic         m_busy = 1'b0;
    int           m_k    = 0;
    logic         m_prev = 1'b0;
    logic [W-1:0] m_lat_m = '0, m_lat_s = '0;
    logic [W-1:0] m_out_m = '0, m_out_s = '0;

    always @(posedge sys_clk or posedge rstn) begin
        if (rstn) begin
            m_busy  = 1'b0;
            m_k     = 0;
            m_prev  = 1'b0;
            m_out_m = '0;
            m_out_s = '0;
        end else begin
            if (m_busy) begin
                m_k = m_k + 1;
                if (m_k == LAST + 1) begin
                    m_out_s = m_lat_m;
                    m_out_m = m_lat_s;
                    m_busy  = 1'b0;
                end
            end else if (t_start && !m_prev) begin
                m_busy  = 1'b1;
                m_k     = 0;
                m_lat_m = d_in_m;
                m_lat_s = d_in_s;
            end
            m_prev = t_start;
        end
    end

    function automatic logic line_bit(input logic [W-1:0] word, input logic busy, input int k);
        int j;
        if (!busy || k >= LAST) return 1'b0;
        j = k / (2 * D);
`ifdef SPI_MAIN_LSB_FIRST_EN
        return word[j];
`else
        return word[W-1-j];
`endif
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: one start pulse, walk the transfer, optionally change d_in_m at offset chg_k
    task automatic xfer(input logic [W-1:0] m, input logic [W-1:0] s, input int chg_k,
                        input logic [W-1:0] chg_val, output logic [W-1:0] mseq, output logic [W-1:0] sseq);
        mseq = '0;
        sseq = '0;
        d_in_m = m;
        d_in_s = s;
        @(negedge sys_clk);
        t_start = 1'b1;
        @(negedge sys_clk);
        t_start = 1'b0;
        for (int k = 0; k <= LAST + 1; k++) begin
            if (k > 0) @(negedge sys_clk);
            if (k == chg_k) d_in_m = chg_val;
            if (k < LAST && (k % (2 * D)) == 0) begin
                mseq = {mseq[W-2:0], mosi};
                sseq = {sseq[W-2:0], miso};
            end
        end
    endtask

    logic [W-1:0] ms, ss;
    logic [W-1:0] exp_mseq, exp_sseq;

    initial begin
        rstn    = 1'b1;
        t_start = 1'b0;
        d_in_m  = '0;
        d_in_s  = '0;

        // per-cycle compare against the model
        fork
            forever begin
                @(negedge sys_clk);
                check("d_out_m", d_out_m, m_out_m);
                check("d_out_s", d_out_s, m_out_s);
                check("mosi", {7'b0, mosi}, {7'b0, line_bit(m_lat_m, m_busy, m_k)});
                check("miso", {7'b0, miso}, {7'b0, line_bit(m_lat_s, m_busy, m_k)});
            end
        join_none

        repeat (3) @(negedge sys_clk);
        check("rst_d_out_m", d_out_m, 8'h00);
        check("rst_d_out_s", d_out_s, 8'h00);
        check("rst_mosi", {7'b0, mosi}, 8'h00);
        #2 rstn = 1'b0;

        // 0xAB / 0xCD with serial sequences
`ifdef SPI_MAIN_LSB_FIRST_EN
        exp_mseq = 8'b11010101;
        exp_sseq = 8'b10110011;
`else
        exp_mseq = 8'b10101011;
        exp_sseq = 8'b11001101;
`endif
        xfer(8'hAB, 8'hCD, -1, 8'h00, ms, ss);
        check("ab_d_out_s", d_out_s, 8'hAB);
        check("ab_d_out_m", d_out_m, 8'hCD);
        check("ab_mosi_seq", ms, exp_mseq);
        check("ab_miso_seq", ss, exp_sseq);

        // back-to-back swaps
        xfer(8'hFF, 8'h00, -1, 8'h00, ms, ss);
        check("b2b1_d_out_s", d_out_s, 8'hFF);
        check("b2b1_d_out_m", d_out_m, 8'h00);
        xfer(8'h00, 8'hFF, -1, 8'h00, ms, ss);
        check("b2b2_d_out_s", d_out_s, 8'h00);
        check("b2b2_d_out_m", d_out_m, 8'hFF);

        // input change after the start edge is ignored
        xfer(8'h12, 8'h34, 2, 8'hFF, ms, ss);
        check("late_d_out_s", d_out_s, 8'h12);
        check("late_d_out_m", d_out_m, 8'h34);

        // held start fires once
        d_in_m = 8'h5A;
        d_in_s = 8'hA5;
        @(negedge sys_clk);
        t_start = 1'b1;
        repeat (20) @(negedge sys_clk);
        d_in_m = 8'h3C;
        d_in_s = 8'hC3;
        repeat (20) @(negedge sys_clk);
        check("hold_d_out_s", d_out_s, 8'h5A);
        check("hold_d_out_m", d_out_m, 8'hA5);
        t_start = 1'b0;
        xfer(8'h3C, 8'hC3, -1, 8'h00, ms, ss);
        check("repulse_d_out_s", d_out_s, 8'h3C);
        check("repulse_d_out_m", d_out_m, 8'hC3);

        // reset mid-transfer
        d_in_m = 8'h77;
        d_in_s = 8'h88;
        @(negedge sys_clk);
        t_start = 1'b1;
        @(negedge sys_clk);
        t_start = 1'b0;
        repeat (6) @(negedge sys_clk);
        #2 rstn = 1'b1;
        #1;
        check("abort_d_out_m", d_out_m, 8'h00);
        check("abort_d_out_s", d_out_s, 8'h00);
        check("abort_lines", {6'b0, mosi, miso}, 8'h00);
        @(negedge sys_clk);
        #2 rstn = 1'b0;
        repeat (20) @(negedge sys_clk);
        check("post_abort_d_out_s", d_out_s, 8'h00);
        check("post_abort_d_out_m", d_out_m, 8'h00);
        xfer(8'h96, 8'h69, -1, 8'h00, ms, ss);
        check("recover_d_out_s", d_out_s, 8'h96);
        check("recover_d_out_m", d_out_m, 8'h69);

        repeat (3) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_main_pair.md
Name: spi_main_pair

Overview:
- Self-contained SPI link: one SPI master and one SPI slave instantiated together and wired back-to-back on an internal serial clock.
- A start request performs one full-duplex exchange of one REG_WIDTH-bit word. Master word d_in_m lands in d_out_s; slave word d_in_s lands in d_out_m.
- mosi and miso are brought out as observation outputs.
- Used as a loopback/bring-up block for the SPI subsystem.

Parameters:
- REG_WIDTH, 8, word width in bits for both shift registers and data ports.
- CLK_DIV, 1, sys_clk cycles per internal SCK half-period (≥1).

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  reset, asynchronous, active-high (asserted = 1), despite the name.
- t_start  input  1  transfer request; rising-edge qualified.
- d_in_m  input  REG_WIDTH  word transmitted by master.
- d_in_s  input  REG_WIDTH  word transmitted by slave.
- d_out_m  output  REG_WIDTH  word received by master (registered).
- d_out_s  output  REG_WIDTH  word received by slave (registered).
- mosi  output  1  master-out serial line (registered).
- miso  output  1  slave-out serial line (registered).

Behaviour:
- Reset (rstn=1, async): state IDLE; d_out_m=0, d_out_s=0, mosi=0, miso=0; internal SCK=0; bit counter=0; t_start edge-detect register=0.
- FSM states: IDLE, TRANSFER, DONE.
- IDLE:
  - Start on edge E0 where t_start=1 and the previous sampled t_start=0.
  - At E0: latch d_in_m into the master shift register and d_in_s into the slave shift register. Drive mosi=d_in_m[MSB] and miso=d_in_s[MSB]. Go to TRANSFER.
  - A t_start held high does not retrigger.
- TRANSFER (SPI mode 0: CPOL=0, CPHA=0; internal SCK idles low):
  - SCK toggles every CLK_DIV sys_clk cycles.
  - SCK rising: master samples miso into receive LSB; slave samples mosi into receive LSB.
  - SCK falling: both transmit registers shift left; mosi/miso present the next bit.
  - Counter counts REG_WIDTH rising edges. After the REG_WIDTH-th rising edge, go to DONE.
- DONE (one cycle):
  - d_out_m <= master receive register; d_out_s <= slave receive register.
  - SCK=0, mosi=0, miso=0. Go to IDLE.
- Latency:
  - d_out_* update at edge E0 + 2*REG_WIDTH*CLK_DIV + 1 (17 cycles at defaults).
  - Next start is accepted no earlier than the following cycle, and needs a fresh t_start rising edge.
- d_in_m/d_in_s changes after E0 are ignored until the next start.
- d_out_* hold their value between transfers; they change only in DONE or on reset.
- t_start edges during TRANSFER/DONE are ignored; no queuing.
- Reset mid-transfer: immediate abort to reset values; no partial word is written to d_out_*.
- mosi/miso are 0 whenever the FSM is not in TRANSFER.

Optional Feature:
- Macro SPI_MAIN_LSB_FIRST_EN.
  - Defined: both sides transmit LSB first. The first bit driven at E0 is d_in_x[0]. Transmit registers shift right. Received bits enter at the MSB and shift right.
  - Undefined (default): MSB-first, as above.
  - Either way, after a transfer d_out_s==d_in_m and d_out_m==d_in_s.

Test Plan:
- Reset: assert rstn=1 mid-operation -> d_out_m=0x00, d_out_s=0x00, mosi=0, miso=0 immediately, without waiting for a clock edge.
- d_in_m=0xAB, d_in_s=0xCD, pulse t_start -> at E0+17: d_out_s=0xAB, d_out_m=0xCD. mosi serial sequence 1,0,1,0,1,0,1,1; miso sequence 1,1,0,0,1,1,0,1.
- d_in_m=0xFF, d_in_s=0x00, then d_in_m=0x00, d_in_s=0xFF on back-to-back starts -> outputs swap per transfer; previous values held until each DONE.
- Change d_in_m from 0x12 to 0xFF two cycles after E0 -> d_out_s=0x12.
- Hold t_start high for 40 cycles -> exactly one transfer; re-pulse -> second transfer.
- Assert rstn at E0+6 -> d_out_* stay 0x00; subsequent t_start edge performs a clean full transfer.
